multiword_add_ctrl: RTL



---
 rtl/multiword_add_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/multiword_add_ctrl.sv
// Wide adder controller: one N-bit adder slice is reused W times, and the
// carry ripples from word to word through a register.

module full_adder_Nb #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
endmodule

// state | meaning
// IDLE  | waiting for start; s/cout hold the last result
// RUN   | adding word idx of the latched operands, one word per cycle
// DONE  | one-cycle completion; done=1, cout valid
module multiword_add_ctrl #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N*W-1:0] a,
  input  logic [N*W-1:0] b,
  input  logic           cin,
  output logic           busy,
  output logic           done,
  output logic [N*W-1:0] s,
  output logic           cout
);
  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [N*W-1:0] a_q;
  logic [N*W-1:0] b_q;
  logic           carry;
  logic [IW-1:0]  idx;

  logic [N-1:0]   a_word;
  logic [N-1:0]   b_word;
  logic [N-1:0]   sum_word;
  logic           sum_cout;
  logic           last_word;

  // Word select written as a loop so a non-power-of-two W never indexes
  // past the operand registers.
  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int i = 0; i < W; i++) begin
      if (idx == IW'(i)) begin
        a_word = a_q[i*N +: N];
        b_word = b_q[i*N +: N];
      end
    end
  end

  assign last_word = (idx == IW'(W - 1));

  full_adder_Nb #(.N(N)) u_adder (
    .a    (a_word),
    .b    (b_word),
    .cin  (carry),
    .s    (sum_word),
    .cout (sum_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      s     <= '0;
      cout  <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < W; i++) begin
            if (idx == IW'(i)) s[i*N +: N] <= sum_word;
          end
          carry <= sum_cout;
          if (last_word) begin
            cout  <= sum_cout;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
